dmem_port_arbiter: RTL

//  Shares the single-port byte-lane data RAM (DCatch, 4 x 8-bit lanes) between the core

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_addr_decode.sv | 23 ++
 rtl/dmem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and encodings for the data-RAM port arbiter.
package dmem_pkg;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'h0000_1000;
  localparam int unsigned DEPTH_WORDS_DEF = 2048;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic {
    CORE_PRI    = 1'b0,
    HOST_FORCED = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to RAM word index; flags misaligned or out-of-window accesses.
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned AW          = 11
) (
  input  logic [31:0]   i_addr,
  output logic [AW-1:0] o_idx,
  output logic          o_err
);

  logic [31:0] w_off;
  logic [31:0] w_word;

  // Addresses below the base wrap to a huge offset and land in the range error.
  assign w_off  = i_addr - BASE_ADDR;
  assign w_word = w_off >> 2;
  assign o_idx  = w_word[AW-1:0];
  assign o_err  = (i_addr[1:0] != 2'b00) || (w_word >= DEPTH_WORDS);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the core load/store port and the host port.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter int unsigned DEPTH_WORDS  = DEPTH_WORDS_DEF,
  parameter int unsigned AW           = $clog2(DEPTH_WORDS),
  parameter int unsigned MAX_CORE_RUN = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [31:0]   i_core_addr,
  input  logic [3:0]    i_core_wstrb,
  input  logic [31:0]   i_core_wdata,
  output logic          o_core_gnt,
  output logic          o_core_rvalid,
  output logic [31:0]   o_core_rdata,
  output logic          o_core_err,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [31:0]   i_host_addr,
  input  logic [3:0]    i_host_wstrb,
  input  logic [31:0]   i_host_wdata,
  output logic          o_host_gnt,
  output logic          o_host_rvalid,
  output logic [31:0]   o_host_rdata,
  output logic          o_host_err,
  output logic          o_ram_en,
  output logic [3:0]    o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_wdata,
  input  logic [31:0]   i_ram_rdata
);

  localparam int unsigned RW = $clog2(MAX_CORE_RUN + 1);

  logic [AW-1:0] w_core_idx;
  logic [AW-1:0] w_host_idx;
  logic          w_core_bad;
  logic          w_host_bad;

  dmem_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_core_decode (
    .i_addr(i_core_addr),
    .o_idx (w_core_idx),
    .o_err (w_core_bad)
  );

  dmem_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_host_decode (
    .i_addr(i_host_addr),
    .o_idx (w_host_idx),
    .o_err (w_host_bad)
  );

  state_e        r_state;
  state_e        w_state_nxt;
  logic [RW-1:0] r_run;
  logic [RW-1:0] w_run_nxt;
  logic          w_any_gnt;
  logic          w_err;
  logic          w_we;
  owner_e        r_owner;
  logic          r_rvalid;
  logic          r_err;
  logic          r_load;

  always_comb begin
    o_core_gnt  = 1'b0;
    o_host_gnt  = 1'b0;
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    case (r_state)
      HOST_FORCED: begin
        o_host_gnt  = i_host_req;
        o_core_gnt  = i_core_req & ~i_host_req;
        // The forced slot lasts one cycle whether or not the host still wants it.
        w_state_nxt = CORE_PRI;
        w_run_nxt   = '0;
      end
      default: begin
        o_core_gnt = i_core_req;
        o_host_gnt = i_host_req & ~i_core_req;
        if (!i_host_req || o_host_gnt) begin
          w_run_nxt = '0;
        end else if (o_core_gnt) begin
          w_run_nxt = r_run + 1'b1;
          if (r_run == RW'(MAX_CORE_RUN - 1)) begin
            w_state_nxt = HOST_FORCED;
          end
        end
      end
    endcase
  end

  assign w_any_gnt = o_core_gnt | o_host_gnt;

  always_comb begin
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_we    = '0;
    w_err       = 1'b0;
    w_we        = 1'b0;
    if (o_host_gnt) begin
      w_err       = w_host_bad;
      w_we        = i_host_we;
      o_ram_addr  = w_host_idx;
      o_ram_wdata = i_host_wdata;
      o_ram_we    = i_host_wstrb & {4{i_host_we}};
    end else if (o_core_gnt) begin
      w_err       = w_core_bad;
      w_we        = i_core_we;
      o_ram_addr  = w_core_idx;
      o_ram_wdata = i_core_wdata;
      o_ram_we    = i_core_wstrb & {4{i_core_we}};
    end
    o_ram_en = w_any_gnt & ~w_err;
    if (w_err) begin
      o_ram_we = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= CORE_PRI;
      r_run    <= '0;
      r_rvalid <= 1'b0;
      r_owner  <= OWN_CORE;
      r_err    <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_rvalid <= w_any_gnt;
      r_owner  <= o_host_gnt ? OWN_HOST : OWN_CORE;
      r_err    <= w_err;
      r_load   <= ~w_we;
    end
  end

  // Only error-free loads return RAM data; stores and errors answer with zero.
  assign o_core_rvalid = r_rvalid & (r_owner == OWN_CORE);
  assign o_core_err    = o_core_rvalid & r_err;
  assign o_core_rdata  = (o_core_rvalid & ~r_err & r_load) ? i_ram_rdata : '0;
  assign o_host_rvalid = r_rvalid & (r_owner == OWN_HOST);
  assign o_host_err    = o_host_rvalid & r_err;
  assign o_host_rdata  = (o_host_rvalid & ~r_err & r_load) ? i_ram_rdata : '0;

endmodule
